// File: rtl/lzc_pkg.sv
// Shared types and helpers for the multi-cycle leading/trailing zero/one scanner.
package lzc_pkg;

    typedef enum logic [1:0] {
        LZC_LZ = 2'd0,
        LZC_LO = 2'd1,
        LZC_TZ = 2'd2,
        LZC_TO = 2'd3
    } lzc_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lzc_state_t;

    function automatic int lzc_cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/lzc_chunk_enc.sv
// Combinational leading-zero priority encoder for one CHUNK-bit slice.
// The output is meaningful only when data is nonzero.
module lzc_chunk_enc #(
    parameter  int CHUNK = 8,
    localparam int LW    = (CHUNK > 1) ? $clog2(CHUNK) : 1
) (
    input  logic [CHUNK-1:0] data,
    output logic [LW-1:0]    count
);

    // Ascending scan so the highest set bit is the last to assign.
    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (data[i]) begin
                count = LW'(CHUNK - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lzc_scanner.sv
// Multi-cycle LZ/LO/TZ/TO counter: the input word is normalised to a
// leading-zero problem, then scanned one CHUNK slice per cycle from the MSB.
module lzc_scanner
    import lzc_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int CHUNK = 8,
    localparam int CW    = lzc_cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             out_none
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LW     = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    lzc_state_t       state, state_next;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] pre;
    logic [WIDTH-1:0] norm;
    logic [CW-1:0]    acc;
    logic [IW-1:0]    idx;
    logic             started;
    logic             inv;
    logic             rev;
    logic [CHUNK-1:0] top;
    logic [LW-1:0]    top_lz;
    logic             top_hit;
    logic             last;
    logic             accept;

    // started keeps in_ready low while reset is held, without a path from rst_n.
    assign in_ready  = (state == IDLE) && started;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    assign top     = sreg[WIDTH-1 -: CHUNK];
    assign top_hit = |top;
    assign last    = (idx == IW'(NCHUNK - 1));

    lzc_chunk_enc #(.CHUNK(CHUNK)) u_enc (
        .data  (top),
        .count (top_lz)
    );

    always_comb begin
        inv = 1'b0;
        rev = 1'b0;
        case (lzc_mode_t'(in_mode))
            LZC_LZ: begin end
            LZC_LO: inv = 1'b1;
            LZC_TZ: rev = 1'b1;
            LZC_TO: begin
                inv = 1'b1;
                rev = 1'b1;
            end
            default: begin end
        endcase
    end

    always_comb begin
        pre  = inv ? ~in_data : in_data;
        norm = pre;
        if (rev) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                norm[i] = pre[WIDTH-1-i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SCAN;
            SCAN:    if (top_hit || last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            started   <= 1'b0;
            sreg      <= '0;
            acc       <= '0;
            idx       <= '0;
            out_count <= '0;
            out_none  <= 1'b0;
        end else begin
            started <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg <= norm;
                        acc  <= '0;
                        idx  <= '0;
                    end
                end
                SCAN: begin
                    if (top_hit) begin
                        out_count <= acc + CW'(top_lz);
                        out_none  <= 1'b0;
                    end else if (last) begin
                        out_count <= CW'(WIDTH);
                        out_none  <= 1'b1;
                    end else begin
                        acc  <= acc + CW'(CHUNK);
                        sreg <= sreg << CHUNK;
                        idx  <= idx + IW'(1);
                    end
                end
                default: begin end
            endcase
        end
    end

endmodule

// File: tb/tb_lzc_scanner.sv
// Directed bench for lzc_scanner at WIDTH=32, CHUNK=8.
module tb_lzc_scanner;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int CW    = 6;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic [1:0]       in_mode   = 2'd0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [CW-1:0]    out_count;
    logic             out_none;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lzc_scanner #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_none  (out_none)
    );

    // Directed vectors: mode, data, expected count, none flag, latency.
    logic [1:0]  tm_mode  [9] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd0};
    logic [31:0] tm_data  [9] = '{32'h0001_0000, 32'h0000_0000, 32'h8000_0000,
                                 32'hFFFF_FFF0, 32'h0000_0100, 32'h0000_00FF,
                                 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    int          tm_count [9] = '{15, 32, 0, 28, 8, 8, 32, 0, 31};
    logic        tm_none  [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          tm_lat   [9] = '{2, 4, 1, 4, 2, 2, 4, 1, 4};

    // Waits (bounded) for in_ready, then presents one word for a single edge.
    task automatic do_accept(input logic [1:0] mode, input logic [31:0] data);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_wait: in_ready=%b expected 1", in_ready);
        end
        in_mode  = mode;
        in_data  = data;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        tests_run++;
        if (out_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL reset_out_count: got %0d expected 0", out_count);
        end
        tests_run++;
        if (out_none !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_none: got %b expected 0", out_none);
        end
        rst_n = 1'b1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_in_ready_early: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_modes();
        int lat;
        for (int i = 0; i < 9; i++) begin
            do_accept(tm_mode[i], tm_data[i]);
            wait_valid(lat);
            tests_run++;
            if (lat !== tm_lat[i]) begin
                tests_failed++;
                $display("FAIL mode_latency[%0d]: got %0d expected %0d", i, lat, tm_lat[i]);
            end
            tests_run++;
            if (out_count !== CW'(tm_count[i])) begin
                tests_failed++;
                $display("FAIL mode_count[%0d]: got %0d expected %0d", i, out_count, tm_count[i]);
            end
            tests_run++;
            if (out_none !== tm_none[i]) begin
                tests_failed++;
                $display("FAIL mode_none[%0d]: got %b expected %b", i, out_none, tm_none[i]);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            tests_run++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL mode_release[%0d]: out_valid=%b in_ready=%b expected 0/1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        do_accept(2'd0, 32'h0001_0000);
        wait_valid(lat);
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("FAIL bp_latency: got %0d expected 2", lat);
        end
        for (int c = 0; c < 5; c++) begin
            in_data  = $urandom;
            in_mode  = 2'(c);
            in_valid = 1'b1;
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || out_count !== 6'd15 || out_none !== 1'b0
                || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: valid=%b count=%0d none=%b in_ready=%b expected 1/15/0/0",
                         c, out_valid, out_count, out_none, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_scan();
        int   lat;
        logic seen = 1'b0;
        do_accept(2'd0, 32'h0000_0000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_in_ready_low: got %b expected 0", in_ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        tests_run++;
        if (seen !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_no_result: out_valid seen=%b expected 0", seen);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_in_ready: got %b expected 1", in_ready);
        end
        do_accept(2'd0, 32'h00F0_0000);
        wait_valid(lat);
        tests_run++;
        if (lat !== 2 || out_count !== 6'd8 || out_none !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_next: lat=%0d count=%0d none=%b expected 2/8/0",
                     lat, out_count, out_none);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [3] = '{32'h8000_0000, 32'h0080_0000, 32'h0000_0001};
        int exp_res [3] = '{0, 8, 31};
        int exp_gap [3] = '{3, 4, 6};
        int acc_cyc [4];
        int res [3];
        int k = 0;
        int nres = 0;
        out_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            if (out_valid === 1'b1 && nres < 3) begin
                res[nres] = int'(out_count);
                nres++;
            end
            if (in_ready === 1'b1 && k < 4) begin
                acc_cyc[k] = cyc;
                if (k < 3) begin
                    in_data  = w[k];
                    in_mode  = 2'd0;
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                k++;
            end
            if (k == 4 && nres == 3) break;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests_run++;
        if (k !== 4 || nres !== 3) begin
            tests_failed++;
            $display("FAIL b2b_progress: accepts=%0d results=%0d expected 4/3", k, nres);
        end else begin
            for (int i = 0; i < 3; i++) begin
                tests_run++;
                if (res[i] !== exp_res[i]) begin
                    tests_failed++;
                    $display("FAIL b2b_count[%0d]: got %0d expected %0d", i, res[i], exp_res[i]);
                end
                tests_run++;
                if (acc_cyc[i+1] - acc_cyc[i] !== exp_gap[i]) begin
                    tests_failed++;
                    $display("FAIL b2b_gap[%0d]: got %0d expected %0d",
                             i, acc_cyc[i+1] - acc_cyc[i], exp_gap[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_reset_mid_scan();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lzc_scanner.md
# lzc_scanner

Parametrised, multi-cycle leading/trailing zero/one counter with valid/ready handshakes on both sides. Each accepted word is scanned one CHUNK-bit slice per cycle, MSB-first after mode normalisation, and the scan stops at the first slice that contains a set bit. The block sits in the datapath wherever normalisation shift amounts or priority indices are needed for words wider than a single-cycle priority encoder can close timing on.

## Interface
- WIDTH, 32: data width; must be a multiple of CHUNK.
- CHUNK, 8: bits examined per scan cycle; NCHUNK = WIDTH/CHUNK.
- CW (localparam), $clog2(WIDTH+1): count width.

- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  word to scan.
- in_mode  in  2  0 = LZ (leading zeros), 1 = LO (leading ones), 2 = TZ (trailing zeros), 3 = TO (trailing ones).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_count  out  CW  count of matching bits from the scan end.
- out_none  out  1  whole word matched, i.e. no terminating bit; out_count = WIDTH.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready:
  - Transform in_data: invert for LO/TO; bit-reverse for TZ/TO.
  - Load the result into the shift register; clear acc and idx; go to SCAN.
  - The transformed word is always counted as leading zeros.
- SCAN: in_ready = 0. Examine the top CHUNK bits of the shift register.
  - Slice nonzero: acc + lz(slice) → out_count; out_none = 0; go to DONE.
  - Slice zero, idx == NCHUNK-1: out_count = WIDTH; out_none = 1; go to DONE.
  - Slice zero otherwise: acc += CHUNK; shift left by CHUNK; idx++; stay in SCAN.
- DONE: out_valid = 1; out_count and out_none are held stable.
  - On out_ready: go to IDLE.
  - No new word is accepted in DONE.
- Arithmetic: acc, out_count and idx never overflow; max acc is WIDTH, which fits in CW bits. lz of a zero slice is never used.
- in_data and in_mode are sampled only on the input handshake. Changes at any other time have no effect.
- Reset (rst_n low at a clk edge), at any state including mid-SCAN:
  - state = IDLE; out_valid = 0; out_count = 0; out_none = 0; acc/idx = 0.
  - In-flight word is discarded; no result for it is ever produced.
  - in_ready = 0 while rst_n is low, then 1 from the first cycle after release.

## Timing
- Input handshake at edge E0. First nonzero slice at index j (0-based from scan start) → out_valid rises at edge E0+j+1.
- Latency: min 1 cycle, max NCHUNK cycles (all-match word).
- out_valid remains high until the edge where out_valid & out_ready; it deasserts at that edge, and in_ready rises in the same cycle.
- Throughput: one word per j+3 cycles with out_ready tied high (IDLE + j+1 SCAN + DONE).
- No combinational path from in_valid to in_ready or from out_ready to out_valid. in_ready and out_valid decode from the registered state only.

## Structure
- lzc_pkg holds:
  - the mode enum (LZC_LZ, LZC_LO, LZC_TZ, LZC_TO);
  - the state enum (IDLE, SCAN, DONE);
  - the function lzc_cw(width) = $clog2(width+1).
- Sub-module lzc_chunk_enc: combinational CHUNK-bit leading-zero priority encoder, output $clog2(CHUNK) bits, valid only for nonzero input. It is instantiated once on the top slice.
- Top level contains the transform, shift register, FSM, accumulator and output registers.

## Test plan
All scenarios use WIDTH=32, CHUNK=8.
- LZ, in_data=0x0001_0000 → out_count=15, out_none=0; out_valid 2 cycles after accept.
- LZ, in_data=0x0000_0000 → out_count=32, out_none=1, latency 4. LZ, 0x8000_0000 → out_count=0, latency 1.
- Modes:
  - LO, 0xFFFF_FFF0 → 28, latency 4.
  - TZ, 0x0000_0100 → 8, latency 2.
  - TO, 0x0000_00FF → 8, latency 2.
  - TO, 0xFFFF_FFFF → 32 with out_none=1.
- Backpressure: out_ready low for 5 cycles after out_valid → out_valid, out_count and out_none are stable and in_ready=0 throughout; in_data toggling has no effect; release → in_ready=1 the next cycle.
- Reset mid-scan: LZ 0x0000_0000 accepted, rst_n low for 1 cycle at E0+2 → out_valid never rises for that word; in_ready=1 after release; next word 0x00F0_0000 → out_count=8.
- Back-to-back: 3 words 0x8000_0000, 0x0080_0000, 0x0000_0001 with in_valid and out_ready held high → counts 0, 8, 31; accepts spaced 3, 4 and 6 cycles apart (j+3).
